lsu_seq: RTL
============

Name: lsu_seq

Overview:
Sequential, parametrised load/store unit between decode and the data cache. It accepts one memory request at a time and derives byte enables from the address low bits and access size. It lane-aligns store data, holds the cache request until the cache completes, then aligns and sign- or zero-extends load data into a registered response. Misaligned accesses are rejected with an error response, and no cache request is issued for them.

Parameters:
DATA_WIDTH, 32, datapath/address width; legal values are 32 or 64.
BYTE_DATA_WIDTH, DATA_WIDTH/8, number of byte lanes (derived; do not override).
TIMEOUT_CYCLES, 64, watchdog limit in cycles (used only with LSU_TIMEOUT_EN).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
mem_req  in  1  decode request valid.
mem_ready  out  1  LSU can accept a request (high only in IDLE).
mem_we  in  1  1 = store, 0 = load.
mem_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword (3 is legal only if DATA_WIDTH=64).
mem_unsigned  in  1  load zero-extend (1) or sign-extend (0).
mem_addr  in  DATA_WIDTH  byte address.
mem_wdata  in  DATA_WIDTH  store data, right-justified.
mem_valid  out  1  one-cycle response pulse.
mem_error  out  1  qualifies mem_valid: access was misaligned, illegal size, or timed out.
result_data  out  DATA_WIDTH  load result; 0 for stores and errors.
data_req  out  1  cache request, held until data_valid.
data_we  out  1  cache write enable.
data_addr  out  DATA_WIDTH  word-aligned address (low log2(BYTE_DATA_WIDTH) bits zeroed).
wdata  out  DATA_WIDTH  lane-shifted store data.
byte_enable  out  BYTE_DATA_WIDTH  active lanes.
data_valid  in  1  cache completion; read data is valid in the same cycle.
rdata  in  DATA_WIDTH  full-word read data.

Behaviour:
- Reset (sync, rst=1 at the edge): state goes to IDLE. Outputs after reset: mem_ready=1, mem_valid=0, mem_error=0, result_data=0, data_req=0, data_we=0, data_addr=0, wdata=0, byte_enable=0. Reset mid-transaction abandons it silently and drops data_req the next cycle; a data_valid arriving after reset is ignored.
- Accept: the request is taken on a cycle where mem_req && mem_ready. All request fields are captured into registers at that edge, and later changes on the decode inputs have no effect.
- Legality check at accept:
  - Misaligned: addr mod (1<<size) != 0.
  - Illegal size: size=3 when DATA_WIDTH=32.
  - On either, go to RESP with error=1, data_req never asserted, result_data=0.
- byte_enable: ((1<<(1<<size))-1) << addr[low bits].
- wdata: mem_wdata << (8*addr[low bits]). Bytes outside the enabled lanes are don't-care but are driven as the shifted value.
- States:
  - IDLE: mem_ready=1. On accept of a legal request, go to WAIT.
  - WAIT: data_req=1 with addr, we, byte_enable and wdata all stable. When data_valid=1, capture the result and go to RESP.
  - RESP: mem_valid=1 for exactly one cycle, with mem_error and result_data valid. Next state is IDLE. mem_ready=0 in RESP, so back-to-back throughput is one request per 3+N cycles.
- Latency:
  - Accept at edge 0; data_req is high from cycle 1.
  - data_valid sampled at edge k gives mem_valid in cycle k+1.
  - With a zero-wait cache (data_valid in cycle 1), mem_valid is in cycle 2.
  - An error response arrives in cycle 1.
- Load alignment: the value is rdata >> (8*addr low bits), truncated to 8<<size bits. It is then sign-extended from its MSB if mem_unsigned=0, else zero-extended. Full-width accesses pass through unchanged.
- Stores: result_data=0, mem_error=0 on completion.
- data_valid outside WAIT is ignored.

Optional Feature:
LSU_TIMEOUT_EN
- Defined: a counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT and increments each WAIT cycle without data_valid. When it reaches TIMEOUT_CYCLES, data_req drops, the LSU goes to RESP with mem_error=1 and result_data=0, and a later stray data_valid is ignored. data_valid on the same cycle as the limit wins, giving a normal completion.
- Undefined: no counter; WAIT persists indefinitely until data_valid or rst.

Decomposition:
- Package lsu_pkg:
  - Size encoding localparams SIZE_B=2'd0, SIZE_H=2'd1, SIZE_W=2'd2, SIZE_D=2'd3.
  - State encoding IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
- Sub-module lsu_align: purely combinational. Computes byte_enable, shifted wdata and the misaligned flag from addr/size/wdata, and the extended load result from rdata/addr/size/unsigned. The FSM/register shell stays in lsu_seq.

Test Plan:
- Byte load, sign-extended: addr=0x1003, size=0, unsigned=0, rdata=0x80AABBCC with data_valid in cycle 1 -> byte_enable=4'b1000, data_addr=0x1000, result_data=0xFFFFFF80, mem_valid in cycle 2, mem_error=0.
- Halfword store: addr=0x2002, size=1, wdata=0x0000BEEF -> data_we=1, byte_enable=4'b1100, wdata=0xBEEF0000, data_req held through 3 wait cycles, mem_valid=1 with result_data=0 one cycle after data_valid.
- Misaligned word: addr=0x3001, size=2 -> data_req never rises, mem_valid=1 and mem_error=1 in cycle 1, mem_ready=1 in cycle 2.
- Unsigned halfword: addr=0x4002, unsigned=1, rdata=0xF00D1234 -> result_data=0x0000F00D. Also with DATA_WIDTH=32, size=3 -> mem_error=1.
- Reset in WAIT: rst=1 for one cycle, then data_valid=1 -> no mem_valid, data_req=0 the cycle after reset, mem_ready=1.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4: data_valid never asserted -> mem_valid with mem_error=1 after 4 WAIT cycles. With data_valid on the 4th cycle -> normal completion, no error.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the sequential load/store unit: access sizes, FSM states
// and the low-address alignment mask helper.
package lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  // Address bits that must be zero for a naturally aligned access of this size.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    return (3'd1 << size) - 3'd1;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-data shift and alignment check
// for an incoming request, plus extraction and extension of load data.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int BYTE_DATA_WIDTH = DATA_WIDTH / 8
) (
  input  logic [2:0]                         req_addr_lo,
  input  logic [1:0]                         req_size,
  input  logic [DATA_WIDTH-1:0]              req_wdata,
  output logic [BYTE_DATA_WIDTH-1:0]         req_be,
  output logic [DATA_WIDTH-1:0]              req_wdata_sh,
  output logic                               req_misaligned,
  output logic                               req_illegal,
  input  logic [$clog2(BYTE_DATA_WIDTH)-1:0] ld_off,
  input  logic [1:0]                         ld_size,
  input  logic                               ld_unsigned,
  input  logic [DATA_WIDTH-1:0]              rdata,
  output logic [DATA_WIDTH-1:0]              ld_result
);

  localparam int OFF_W = $clog2(BYTE_DATA_WIDTH);

  logic [OFF_W-1:0]      req_off;
  logic [15:0]           lane_mask;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] keep;
  logic                  sign;
  logic                  fill;

  assign req_off        = req_addr_lo[OFF_W-1:0];
  assign lane_mask      = (16'd1 << (5'd1 << req_size)) - 16'd1;
  assign req_be         = lane_mask[BYTE_DATA_WIDTH-1:0] << req_off;
  assign req_wdata_sh   = req_wdata << {req_off, 3'b000};
  assign req_misaligned = (req_addr_lo & align_mask(req_size)) != 3'd0;
  assign req_illegal    = (req_size == SIZE_D) && (DATA_WIDTH == 32);

  // Load: bring the addressed lanes down to bit 0, then replace everything
  // above the access width with the fill bit.
  always_comb begin
    shifted = rdata >> {ld_off, 3'b000};
    keep    = '1;
    sign    = shifted[DATA_WIDTH-1];
    case (ld_size)
      SIZE_B: begin
        keep = DATA_WIDTH'(8'hFF);
        sign = shifted[7];
      end
      SIZE_H: begin
        keep = DATA_WIDTH'(16'hFFFF);
        sign = shifted[15];
      end
      SIZE_W: begin
        keep = DATA_WIDTH'(32'hFFFF_FFFF);
        sign = shifted[31];
      end
      default: begin
        keep = '1;
        sign = shifted[DATA_WIDTH-1];
      end
    endcase
    fill      = ~ld_unsigned & sign;
    ld_result = (shifted & keep) | (~keep & {DATA_WIDTH{fill}});
  end

endmodule

// File: rtl/lsu_seq.sv
// Sequential load/store unit between decode and the data cache (one request in
// flight). Build with LSU_TIMEOUT_EN to add a watchdog on the cache wait.
module lsu_seq
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int BYTE_DATA_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_req,
  output logic                       mem_ready,
  input  logic                       mem_we,
  input  logic [1:0]                 mem_size,
  input  logic                       mem_unsigned,
  input  logic [DATA_WIDTH-1:0]      mem_addr,
  input  logic [DATA_WIDTH-1:0]      mem_wdata,
  output logic                       mem_valid,
  output logic                       mem_error,
  output logic [DATA_WIDTH-1:0]      result_data,
  output logic                       data_req,
  output logic                       data_we,
  output logic [DATA_WIDTH-1:0]      data_addr,
  output logic [DATA_WIDTH-1:0]      wdata,
  output logic [BYTE_DATA_WIDTH-1:0] byte_enable,
  input  logic                       data_valid,
  input  logic [DATA_WIDTH-1:0]      rdata
);

  // Handshakes: decode transfers a request on a cycle with mem_req && mem_ready;
  // the cache sees data_req held with stable fields until it answers with
  // data_valid (completes the access that cycle); mem_valid is a one-cycle
  // response pulse with no back-pressure.

  localparam int OFF_W = $clog2(BYTE_DATA_WIDTH);

  lsu_state_e state, state_n;

  logic                       accept;
  logic                       req_bad;
  logic                       timeout_hit;
  logic [BYTE_DATA_WIDTH-1:0] req_be;
  logic [DATA_WIDTH-1:0]      req_wdata_sh;
  logic                       req_misaligned;
  logic                       req_illegal;
  logic [DATA_WIDTH-1:0]      ld_result;

  logic                       we_q;
  logic [1:0]                 size_q;
  logic                       uns_q;
  logic [OFF_W-1:0]           off_q;
  logic [DATA_WIDTH-1:0]      addr_q;
  logic [BYTE_DATA_WIDTH-1:0] be_q;
  logic [DATA_WIDTH-1:0]      wdata_q;
  logic                       err_q;
  logic [DATA_WIDTH-1:0]      res_q;

  lsu_align #(
    .DATA_WIDTH     (DATA_WIDTH),
    .BYTE_DATA_WIDTH(BYTE_DATA_WIDTH)
  ) u_align (
    .req_addr_lo   (mem_addr[2:0]),
    .req_size      (mem_size),
    .req_wdata     (mem_wdata),
    .req_be        (req_be),
    .req_wdata_sh  (req_wdata_sh),
    .req_misaligned(req_misaligned),
    .req_illegal   (req_illegal),
    .ld_off        (off_q),
    .ld_size       (size_q),
    .ld_unsigned   (uns_q),
    .rdata         (rdata),
    .ld_result     (ld_result)
  );

  assign accept  = mem_req && mem_ready;
  assign req_bad = req_misaligned || req_illegal;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Fires on the last allowed WAIT cycle, so exactly TIMEOUT_CYCLES cycles of
  // data_req are offered; a data_valid on that same cycle still completes.
  assign timeout_hit = (state == WAIT) && !data_valid &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || state != WAIT) begin
      wait_cnt <= '0;
    end else if (!data_valid) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Request fields are frozen at accept so decode may move on immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      size_q  <= SIZE_B;
      uns_q   <= 1'b0;
      off_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      res_q   <= '0;
    end else if (accept) begin
      we_q    <= mem_we;
      size_q  <= mem_size;
      uns_q   <= mem_unsigned;
      off_q   <= mem_addr[OFF_W-1:0];
      addr_q  <= {mem_addr[DATA_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
      be_q    <= req_be;
      wdata_q <= req_wdata_sh;
      err_q   <= req_bad;
      res_q   <= '0;
    end else if (state == WAIT && data_valid) begin
      res_q <= we_q ? '0 : ld_result;
    end else if (timeout_hit) begin
      err_q <= 1'b1;
    end
  end

  always_comb begin
    state_n     = state;
    mem_ready   = 1'b0;
    mem_valid   = 1'b0;
    mem_error   = 1'b0;
    result_data = '0;
    data_req    = 1'b0;
    data_we     = 1'b0;
    data_addr   = '0;
    wdata       = '0;
    byte_enable = '0;
    case (state)
      IDLE: begin
        mem_ready = 1'b1;
        if (mem_req) begin
          state_n = req_bad ? RESP : WAIT;
        end
      end
      WAIT: begin
        data_req    = 1'b1;
        data_we     = we_q;
        data_addr   = addr_q;
        wdata       = wdata_q;
        byte_enable = be_q;
        if (data_valid || timeout_hit) begin
          state_n = RESP;
        end
      end
      RESP: begin
        mem_valid   = 1'b1;
        mem_error   = err_q;
        result_data = res_q;
        state_n     = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
